// File: rtl/fm_pkg.sv
// Shared FM synthesizer definitions: operator/channel counts, op->channel map,
// and the operator sequencer state encoding.
package fm_pkg;

  localparam int NUM_OPS = 36;
  localparam int NUM_CH  = NUM_OPS / 2;
  localparam int IDX_W   = 6;
  localparam int CH_W    = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // Two operators per channel: operator i belongs to channel i>>1.
  function automatic logic [CH_W-1:0] op_ch(input logic [IDX_W-1:0] op);
    return op[IDX_W-1:1];
  endfunction

endpackage

// File: rtl/fm_op_pending.sv
// Per-operator pending flag array: vector set, indexed clear, indexed read.
// A set and a clear of the same bit in one cycle leaves the bit set.
module fm_op_pending
  import fm_pkg::*;
#(
  parameter int                 N_FLAGS = NUM_OPS,
  parameter logic [N_FLAGS-1:0] RST_VAL = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_FLAGS-1:0] set_vec,
  input  logic               clr,
  input  logic [IDX_W-1:0]   clr_idx,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd
);

  localparam logic [IDX_W-1:0] LIMIT = IDX_W'(N_FLAGS);

  logic [N_FLAGS-1:0] flags;
  logic [N_FLAGS-1:0] clr_mask;

  always_comb begin
    clr_mask = '0;
    if (clr && (clr_idx < LIMIT)) clr_mask[clr_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) flags <= RST_VAL;
    else       flags <= (flags & ~clr_mask) | set_vec;
  end

  assign rd = (rd_idx < LIMIT) ? flags[rd_idx] : 1'b0;

endmodule

// File: rtl/fm_op_seq.sv
// Operator time-slot sequencer: walks all operators once per sample tick and
// delivers key-on restarts and operator resets in each operator's own slot.
// Optional sticky overrun flag under FM_SEQ_OVERRUN_EN.
module fm_op_seq #(
  parameter int NUM_OPS     = fm_pkg::NUM_OPS,
  parameter int SLOT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic [NUM_OPS/2-1:0] kon,
  input  logic                 op_reset_req,
  input  logic [5:0]           op_reset_idx,
  output logic [5:0]           op_sel,
  output logic                 next,
  output logic                 restart,
  output logic                 op_reset,
  output logic                 kon_op,
  output logic                 busy,
  output logic                 done
`ifdef FM_SEQ_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam int              NUM_CH    = NUM_OPS / 2;
  localparam int              SC_W      = $clog2(SLOT_CYCLES);
  localparam logic [SC_W-1:0] SLOT_LAST = SC_W'(SLOT_CYCLES - 1);
  localparam logic [5:0]      OP_LAST   = 6'(NUM_OPS - 1);

  fm_pkg::seq_state_t state;
  logic [SC_W-1:0]    slot_cnt;
  logic [NUM_CH-1:0]  kon_q;
  logic [NUM_CH-1:0]  rise_q;
  logic [NUM_OPS-1:0] restart_set;
  logic [NUM_OPS-1:0] reset_set;
  logic               restart_rd;
  logic               reset_rd;

  assign next = busy && (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= fm_pkg::IDLE;
      op_sel   <= '0;
      slot_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        fm_pkg::IDLE: begin
          if (sample_tick) begin
            state    <= fm_pkg::RUN;
            busy     <= 1'b1;
            op_sel   <= '0;
            slot_cnt <= '0;
          end
        end
        fm_pkg::RUN: begin
          // A tick arriving here is ignored; the pass always runs to the end.
          if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            if (op_sel == OP_LAST) begin
              state  <= fm_pkg::IDLE;
              busy   <= 1'b0;
              op_sel <= '0;
              done   <= 1'b1;
            end else begin
              op_sel <= op_sel + 6'd1;
            end
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        default: state <= fm_pkg::IDLE;
      endcase
    end
  end

  // Rising key-on edges are registered once more, giving a two-cycle
  // kon-to-pending latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      kon_q  <= '0;
      rise_q <= '0;
    end else begin
      kon_q  <= kon;
      rise_q <= kon & ~kon_q;
    end
  end

  always_comb begin
    restart_set = '0;
    reset_set   = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      restart_set[i] = rise_q[i/2];
      reset_set[i]   = op_reset_req && (op_reset_idx == 6'(i));
    end
  end

  fm_op_pending #(
    .N_FLAGS (NUM_OPS),
    .RST_VAL ({NUM_OPS{1'b0}})
  ) u_restart_pend (
    .clk     (clk),
    .reset   (reset),
    .set_vec (restart_set),
    .clr     (next),
    .clr_idx (op_sel),
    .rd_idx  (op_sel),
    .rd      (restart_rd)
  );

  // Reset flags come up all set so the first pass initialises every operator.
  fm_op_pending #(
    .N_FLAGS (NUM_OPS),
    .RST_VAL ({NUM_OPS{1'b1}})
  ) u_reset_pend (
    .clk     (clk),
    .reset   (reset),
    .set_vec (reset_set),
    .clr     (next),
    .clr_idx (op_sel),
    .rd_idx  (op_sel),
    .rd      (reset_rd)
  );

  assign restart  = busy & restart_rd;
  assign op_reset = busy & reset_rd;
  assign kon_op   = kon[fm_pkg::op_ch(op_sel)];

`ifdef FM_SEQ_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (reset)                    overrun <= 1'b0;
    else if (sample_tick && busy) overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fm_op_seq.sv
// Directed bench for fm_op_seq: full passes with per-cycle checks of slot
// timing, pending delivery, mid-pass events, overrun and mid-pass reset.
module tb_fm_op_seq;

  localparam int NOPS = 36;
  localparam int SC   = 4;
  localparam int PLEN = NOPS * SC;
  localparam logic [NOPS-1:0] ALL = {NOPS{1'b1}};

  logic            clk;
  logic            reset;
  logic            sample_tick;
  logic [NOPS/2-1:0] kon;
  logic            op_reset_req;
  logic [5:0]      op_reset_idx;
  logic [5:0]      op_sel;
  logic            next;
  logic            restart;
  logic            op_reset;
  logic            kon_op;
  logic            busy;
  logic            done;
`ifdef FM_SEQ_OVERRUN_EN
  logic            overrun;
`endif

  int   checks   = 0;
  int   failures = 0;
  logic exp_ov   = 1'b0;

  fm_op_seq #(
    .NUM_OPS     (NOPS),
    .SLOT_CYCLES (SC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .kon          (kon),
    .op_reset_req (op_reset_req),
    .op_reset_idx (op_reset_idx),
    .op_sel       (op_sel),
    .next         (next),
    .restart      (restart),
    .op_reset     (op_reset),
    .kon_op       (kon_op),
    .busy         (busy),
    .done         (done)
`ifdef FM_SEQ_OVERRUN_EN
    ,
    .overrun      (overrun)
`endif
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp, input int rel);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s rel=%0d observed=%0h expected=%0h", tag, rel, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done, input int rel);
    chk({tag, "_busy"}, 32'(busy), 32'd0, rel);
    chk({tag, "_done"}, 32'(done), 32'(exp_done), rel);
    chk({tag, "_op_sel"}, 32'(op_sel), 32'd0, rel);
    chk({tag, "_next"}, 32'(next), 32'd0, rel);
    chk({tag, "_restart"}, 32'(restart), 32'd0, rel);
    chk({tag, "_op_reset"}, 32'(op_reset), 32'd0, rel);
`ifdef FM_SEQ_OVERRUN_EN
    chk({tag, "_overrun"}, 32'(overrun), 32'(exp_ov), rel);
`endif
  endtask

  // Driver: one pass started by a tick in the current cycle. Events are
  // given as cycle offsets from the tick (-1 = none).
  task automatic run_pass(input logic [NOPS-1:0] exp_rst, input logic [NOPS-1:0] exp_rs,
                          input int req_at, input int req_idx,
                          input int req2_at, input int req2_idx,
                          input int kon_at, input int kon_bit,
                          input int tick_at, input int abort_at);
    int k;
    int c;
    chk("pre_busy", 32'(busy), 32'd0, 0);
    sample_tick = 1'b1;
    step();
    for (int rel = 1; rel <= PLEN; rel++) begin
      sample_tick  = 1'b0;
      op_reset_req = 1'b0;
      k = (rel - 1) / SC;
      c = (rel - 1) % SC;
      chk("busy", 32'(busy), 32'd1, rel);
      chk("op_sel", 32'(op_sel), 32'(k), rel);
      chk("next", 32'(next), 32'(c == SC - 1), rel);
      chk("restart", 32'(restart), 32'(exp_rs[k]), rel);
      chk("op_reset", 32'(op_reset), 32'(exp_rst[k]), rel);
      chk("kon_op", 32'(kon_op), 32'(kon[k/2]), rel);
      chk("done", 32'(done), 32'd0, rel);
`ifdef FM_SEQ_OVERRUN_EN
      chk("overrun", 32'(overrun), 32'(exp_ov), rel);
`endif
      if (rel == abort_at) begin
        reset = 1'b1;
        step();
        exp_ov = 1'b0;
        chk_idle("abort", 1'b0, rel + 1);
        reset = 1'b0;
        for (int j = 2; j <= 3; j++) begin
          step();
          chk_idle("post_abort", 1'b0, rel + j);
        end
        step();
        return;
      end
      if (rel == req_at)  begin op_reset_req = 1'b1; op_reset_idx = 6'(req_idx);  end
      if (rel == req2_at) begin op_reset_req = 1'b1; op_reset_idx = 6'(req2_idx); end
      if (rel == kon_at)  kon[kon_bit] = 1'b1;
      if (rel == tick_at) begin
        sample_tick = 1'b1;
        exp_ov      = 1'b1;
      end
      step();
    end
    sample_tick  = 1'b0;
    op_reset_req = 1'b0;
    chk_idle("end", 1'b1, PLEN + 1);
    step();
    chk_idle("after_end", 1'b0, PLEN + 2);
    step();
    chk_idle("after_end2", 1'b0, PLEN + 3);
  endtask

  initial begin
    logic [NOPS-1:0] m;
    reset        = 1'b1;
    sample_tick  = 1'b0;
    kon          = '0;
    op_reset_req = 1'b0;
    op_reset_idx = '0;
    step(); step(); step();
    chk_idle("reset", 1'b0, 0);
    chk("reset_kon_op", 32'(kon_op), 32'd0, 0);
    reset = 1'b0;
    step();
    chk_idle("idle", 1'b0, 0);

    // First pass resets every operator; second pass resets none.
    run_pass(ALL, '0, -1, 0, -1, 0, -1, 0, -1, -1);
    run_pass('0, '0, -1, 0, -1, 0, -1, 0, -1, -1);

    // Channel 5 key-on while idle -> restart in ops 10/11; op reset for 7
    // requested during slot 3 lands in slot 7; index 40 is dropped.
    kon[5] = 1'b1;
    step(); step(); step();
    m = '0; m[10] = 1'b1; m[11] = 1'b1;
    run_pass(36'd1 << 7, m, 13, 7, 14, 40, -1, 0, -1, -1);

    // Channel 2 rise in cycle 19: its pending set coincides with the slot-4
    // clear, so op 4 keeps it for the next pass; op 5 gets it now.
    // A mid-pass tick at offset 50 must not disturb the pass.
    m = '0; m[5] = 1'b1;
    run_pass('0, m, -1, 0, -1, 0, 19, 2, 50, -1);
    m = '0; m[4] = 1'b1;
    run_pass('0, m, -1, 0, -1, 0, -1, 0, -1, -1);

    // Reset at offset 60 aborts the pass; reset clears kon_q so the held
    // key-ons of channels 2 and 5 are seen as new rises.
    run_pass('0, '0, -1, 0, -1, 0, -1, 0, -1, 60);
    m = '0; m[4] = 1'b1; m[5] = 1'b1; m[10] = 1'b1; m[11] = 1'b1;
    run_pass(ALL, m, -1, 0, -1, 0, -1, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
